// File: rtl/tile_readout_serializer.sv
// rtl/tile_readout_serializer.sv - sample FIFO draining into a start/8-data/stop serial line
module tile_readout_serializer #(
  parameter int DEPTH = 4,
  parameter int DIV   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tile_uo,
  input  logic       capture,
  input  logic       tx_en,
  input  logic       clr_ovf,
  output logic       ser_out,
  output logic       busy,
  output logic [3:0] count,
  output logic       overflow
);

  localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [3:0] FULL     = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_div_cnt;
  logic          r_ser;
  logic          r_ovf;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_tick;

  // A pop frees a slot on the same edge, so a capture at full is still accepted then.
  assign w_full = (r_count == FULL);
  assign w_pop  = (r_state == IDLE) && tx_en && (r_count != 4'd0);
  assign w_push = capture && (!w_full || w_pop);
  assign w_drop = capture && w_full && !w_pop;
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= tile_uo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ser     <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ser     <= 1'b1;
          r_div_cnt <= '0;
          if (w_pop) begin
            r_state <= START;
            r_ser   <= 1'b0;
            r_shift <= r_mem[r_rd_ptr];
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_ser     <= r_shift[7];
            r_bit_idx <= 3'd7;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            if (r_bit_idx == 3'd0) begin
              r_state <= STOP;
              r_ser   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx - 3'd1;
              r_shift   <= {r_shift[6:0], 1'b0};
              r_ser     <= r_shift[6];
            end
          end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_out  = r_ser;
  assign busy     = (r_state != IDLE);
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_tile_readout_serializer.sv
// tb/tb_tile_readout_serializer.sv - DIV=1 and DIV=3 serializers checked against a frame-level model
module tb_tile_readout_serializer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tile_uo;
  logic       capture;
  logic       tx_en;
  logic       clr_ovf;
  logic       ser0, busy0, ovf0;
  logic       ser1, busy1, ovf1;
  logic [3:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  tile_readout_serializer #(.DEPTH(DEPTH), .DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .tile_uo(tile_uo), .capture(capture), .tx_en(tx_en),
    .clr_ovf(clr_ovf), .ser_out(ser0), .busy(busy0), .count(cnt0), .overflow(ovf0)
  );

  tile_readout_serializer #(.DEPTH(DEPTH), .DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .tile_uo(tile_uo), .capture(capture), .tx_en(tx_en),
    .clr_ovf(clr_ovf), .ser_out(ser1), .busy(busy1), .count(cnt1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: unbounded ring of samples plus a "frame in flight" cursor per instance
  logic [7:0] m_buf [2][64];
  int         m_head [2];
  int         m_size [2];
  int         m_pos  [2];
  bit         m_act  [2];
  bit         m_ovf  [2];
  logic [7:0] m_cur  [2];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int div);
    bit pop;
    bit drop;
    if (!rst_n) begin
      m_head[k] = 0;
      m_size[k] = 0;
      m_pos[k]  = 0;
      m_act[k]  = 0;
      m_ovf[k]  = 0;
      return;
    end
    pop  = !m_act[k] && tx_en && (m_size[k] > 0);
    drop = capture && (m_size[k] == DEPTH) && !pop;
    if (m_act[k]) begin
      m_pos[k]++;
      if (m_pos[k] == 10 * div) m_act[k] = 0;
    end else if (pop) begin
      m_act[k]  = 1;
      m_pos[k]  = 0;
      m_cur[k]  = m_buf[k][m_head[k]];
      m_head[k] = (m_head[k] + 1) % 64;
      m_size[k]--;
    end
    if (capture && !drop) begin
      m_buf[k][(m_head[k] + m_size[k]) % 64] = tile_uo;
      m_size[k]++;
    end
    if (drop) m_ovf[k] = 1;
    else if (clr_ovf) m_ovf[k] = 0;
  endtask

  // Symbol index = elapsed cycles / DIV: 0 start, 1..8 data MSB first, 9 stop
  function automatic logic exp_ser(input int k, input int div);
    int idx;
    logic [7:0] b;
    if (!m_act[k]) return 1'b1;
    idx = m_pos[k] / div;
    b   = m_cur[k];
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[8 - idx];
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(0, 1);
    model_step(1, 3);
    #1;
    chk("ser_d1",   32'(ser0),  32'(exp_ser(0, 1)));
    chk("busy_d1",  32'(busy0), 32'(m_act[0]));
    chk("count_d1", 32'(cnt0),  m_size[0]);
    chk("ovf_d1",   32'(ovf0),  32'(m_ovf[0]));
    chk("ser_d3",   32'(ser1),  32'(exp_ser(1, 3)));
    chk("busy_d3",  32'(busy1), 32'(m_act[1]));
    chk("count_d3", 32'(cnt1),  m_size[1]);
    chk("ovf_d3",   32'(ovf1),  32'(m_ovf[1]));
  endtask

  initial begin
    logic [9:0] a5_wave;
    logic [7:0] acc;
    bit  prev;
    int  last_rise, hi, fb, nfr;

    rst_n = 1'b0; tile_uo = '0; capture = 1'b0; tx_en = 1'b0; clr_ovf = 1'b0;
    repeat (2) cycle();
    chk("rst_ser",   32'(ser0),  1);
    chk("rst_busy",  32'(busy0), 0);
    chk("rst_count", 32'(cnt1),  0);
    chk("rst_ovf",   32'(ovf1),  0);
    rst_n = 1'b1;
    cycle();

    // Single A5 frame at DIV=1
    a5_wave = 10'b0101001011;
    tx_en = 1'b1; capture = 1'b1; tile_uo = 8'hA5;
    cycle();
    capture = 1'b0;
    chk("a5_count1", 32'(cnt0), 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("a5_bit",  32'(ser0),  32'(a5_wave[9 - i]));
      chk("a5_busy", 32'(busy0), 1);
    end
    cycle();
    chk("a5_idle",   32'(busy0), 0);
    chk("a5_count0", 32'(cnt0),  0);
    repeat (40) cycle();

    // Five captures into a 4-deep FIFO, then drain at DIV=3
    tx_en = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      tile_uo = 8'(v); capture = 1'b1;
      cycle();
    end
    capture = 1'b0;
    chk("fill_count", 32'(cnt1), 4);
    chk("fill_ovf",   32'(ovf1), 1);
    tx_en = 1'b1;
    prev = busy1; last_rise = -1; hi = 0;
    for (int t = 0; t < 130; t++) begin
      cycle();
      if (busy1 && !prev) begin
        if (last_rise >= 0) chk("frame_gap", t - last_rise, 31);
        last_rise = t;
      end
      if (busy1) hi++;
      if (!busy1 && prev) begin
        chk("frame_len", hi, 30);
        hi = 0;
      end
      prev = busy1;
    end
    chk("drained", 32'(cnt1), 0);

    // Overflow clear, then clear coinciding with a drop
    tx_en = 1'b0; clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf0), 0);
    for (int i = 0; i < 4; i++) begin
      tile_uo = 8'($urandom); capture = 1'b1;
      cycle();
    end
    clr_ovf = 1'b1;
    cycle();
    capture = 1'b0;
    chk("ovf_set_wins", 32'(ovf0), 1);
    cycle();
    clr_ovf = 1'b0;
    chk("ovf_clr2", 32'(ovf0), 0);

    // Capture on the pop edge while full
    tx_en = 1'b1; capture = 1'b1; tile_uo = 8'h77;
    cycle();
    capture = 1'b0;
    chk("popcap_ovf",   32'(ovf0), 0);
    chk("popcap_count", 32'(cnt0), 4);
    fb = 0; nfr = 0; acc = '0;
    for (int t = 0; t < 160; t++) begin
      cycle();
      if (fb >= 0) begin
        fb++;
        if (fb <= 8) acc = {acc[6:0], ser0};
        if (fb == 9) begin
          nfr++;
          if (nfr == 5) chk("fifth_byte", 32'(acc), 32'h77);
          fb = -1;
        end
      end else if (busy0) begin
        fb = 0;
      end
    end
    chk("nframes", nfr, 5);

    // tx_en dropped right after a frame starts
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tile_uo = 8'($urandom); capture = 1'b1;
      cycle();
    end
    capture = 1'b0;
    cycle();
    tx_en = 1'b1;
    cycle();
    tx_en = 1'b0;
    repeat (35) cycle();
    chk("hold_count", 32'(cnt1),  2);
    chk("hold_busy",  32'(busy1), 0);
    tx_en = 1'b1;
    repeat (70) cycle();

    // Reset during DATA bit 4 at DIV=1
    capture = 1'b1; tile_uo = 8'h3C;
    cycle();
    tile_uo = 8'hC3;
    cycle();
    capture = 1'b0;
    repeat (4) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("abort_ser",   32'(ser0),  1);
    chk("abort_busy",  32'(busy0), 0);
    chk("abort_count", 32'(cnt0),  0);
    for (int i = 0; i < 30; i++) begin
      cycle();
      chk("no_frame", 32'(busy0), 0);
    end

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      capture = ($urandom_range(0, 9) < 4);
      tile_uo = 8'($urandom);
      tx_en   = ($urandom_range(0, 9) < 8);
      clr_ovf = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
